// File: rtl/uart_word_tx.sv
// uart_word_tx: sends a 32-bit word as 4 UART bytes, little-endian, LSB first, 8N1.
// Latency: start bit on the line the cycle after accept; tx_done 4*10*CLKS_PER_BIT cycles later.
// Backpressure: word_ready only in IDLE; word_valid while busy is dropped, never queued.
// Optional feature: define UART_TX_PARITY_EN for 8E1 frames (even-parity bit before stop).
module uart_word_tx #(
   parameter int CLKS_PER_BIT = 10416
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        word_valid,
   input  logic [31:0] word_data,
   output logic        word_ready,
   output logic        tx_serial,
   output logic        tx_busy,
   output logic        tx_done,
   output logic [1:0]  byte_idx
);

   localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP,
      S_DONE
   } state_t;

   state_t            state;
   logic [BAUD_W-1:0] baud_cnt;
   logic [2:0]        bit_cnt;
   // Word buffer shifts right one bit per data bit, so the byte on the line is
   // always in [7:0]; after four bytes the whole word has been consumed.
   logic [31:0]       shreg;
`ifdef UART_TX_PARITY_EN
   logic              par_bit;
`endif

   wire baud_last = (baud_cnt == BAUD_LAST);

   // Handshake and busy flags decode straight from the registered state.
   assign word_ready = (state == S_IDLE);
   assign tx_busy    = (state != S_IDLE) && (state != S_DONE);

   // Bit-serializer FSM; line, done pulse and byte index are all registered.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_IDLE;
         baud_cnt  <= '0;
         bit_cnt   <= '0;
         shreg     <= '0;
         tx_serial <= 1'b1;
         tx_done   <= 1'b0;
         byte_idx  <= 2'd0;
`ifdef UART_TX_PARITY_EN
         par_bit   <= 1'b0;
`endif
      end else begin
         tx_done <= 1'b0;
         case (state)
            S_IDLE: begin
               tx_serial <= 1'b1;
               baud_cnt  <= '0;
               bit_cnt   <= '0;
               byte_idx  <= 2'd0;
               if (word_valid) begin
                  shreg     <= word_data;
                  state     <= S_START;
                  tx_serial <= 1'b0;
               end
            end
            S_START: begin
               if (baud_last) begin
                  baud_cnt  <= '0;
                  bit_cnt   <= '0;
                  state     <= S_DATA;
                  tx_serial <= shreg[0];
                  shreg     <= {1'b0, shreg[31:1]};
`ifdef UART_TX_PARITY_EN
                  // Even parity of the byte about to be sent, taken before shifting.
                  par_bit   <= ^shreg[7:0];
`endif
               end else begin
                  baud_cnt <= baud_cnt + BAUD_ONE;
               end
            end
            S_DATA: begin
               if (baud_last) begin
                  baud_cnt <= '0;
                  if (bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                     state     <= S_PARITY;
                     tx_serial <= par_bit;
`else
                     state     <= S_STOP;
                     tx_serial <= 1'b1;
`endif
                  end else begin
                     bit_cnt   <= bit_cnt + 3'd1;
                     tx_serial <= shreg[0];
                     shreg     <= {1'b0, shreg[31:1]};
                  end
               end else begin
                  baud_cnt <= baud_cnt + BAUD_ONE;
               end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
               if (baud_last) begin
                  baud_cnt  <= '0;
                  state     <= S_STOP;
                  tx_serial <= 1'b1;
               end else begin
                  baud_cnt <= baud_cnt + BAUD_ONE;
               end
            end
`endif
            S_STOP: begin
               if (baud_last) begin
                  baud_cnt <= '0;
                  if (byte_idx == 2'd3) begin
                     state     <= S_DONE;
                     tx_done   <= 1'b1;
                     tx_serial <= 1'b1;
                  end else begin
                     // Next byte starts immediately, no idle gap between bytes.
                     byte_idx  <= byte_idx + 2'd1;
                     state     <= S_START;
                     tx_serial <= 1'b0;
                  end
               end else begin
                  baud_cnt <= baud_cnt + BAUD_ONE;
               end
            end
            S_DONE: begin
               state     <= S_IDLE;
               tx_serial <= 1'b1;
               byte_idx  <= 2'd0;
            end
            default: begin
               state     <= S_IDLE;
               tx_serial <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_word_tx.sv
// Directed bench for uart_word_tx with CLKS_PER_BIT=4: reset values, word table,
// back-to-back words, ignored request while busy and reset in the middle of a word.
module tb_uart_word_tx;

   localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
   localparam int FRAME = 11;
   localparam int LAT   = 177;
`else
   localparam int FRAME = 10;
   localparam int LAT   = 161;
`endif
   localparam int WORD_CYC = FRAME * CPB * 4;

   logic        clk;
   logic        reset;
   logic        word_valid;
   logic [31:0] word_data;
   logic        word_ready;
   logic        tx_serial;
   logic        tx_busy;
   logic        tx_done;
   logic [1:0]  byte_idx;

   uart_word_tx #(.CLKS_PER_BIT(CPB)) dut (
      .clk        (clk),
      .reset      (reset),
      .word_valid (word_valid),
      .word_data  (word_data),
      .word_ready (word_ready),
      .tx_serial  (tx_serial),
      .tx_busy    (tx_busy),
      .tx_done    (tx_done),
      .byte_idx   (byte_idx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
      end
   endtask

   // mode 0: drop valid after accept; 1: hold valid with next word; 2: pulse FFFFFFFF while busy
   typedef struct {
      logic [31:0] word;
      logic [7:0]  b0, b1, b2, b3;
      logic [3:0]  par;
      int          mode;
      logic [31:0] next;
   } vec_t;

   vec_t tbl[4];
   logic line_tr[0:255];

   task automatic run_word(input vec_t v, input int idx);
      int n;
      int done_cnt;
      int done_cyc;
      int flag_err;
      logic [1:0]  gap;
      logic [31:0] eb_all;
      logic [7:0]  byt;
      logic [10:0] exp_f;
      logic [10:0] cap_f;
      logic        stable;
      int          base;
      done_cnt = 0;
      done_cyc = -1;
      flag_err = 0;
      gap      = 2'b00;
      eb_all   = {v.b3, v.b2, v.b1, v.b0};
      word_valid = 1'b1;
      word_data  = v.word;
      n = 0;
      while (!word_ready && n < 500) begin
         @(negedge clk);
         n++;
      end
      chk($sformatf("w%0d_accept_wait", idx), n, 0);
      if (!word_ready) return;
      for (int cyc = 1; cyc <= WORD_CYC + 2; cyc++) begin
         @(negedge clk);
         if (cyc <= WORD_CYC) begin
            line_tr[cyc-1] = tx_serial;
            if (tx_busy !== 1'b1 || word_ready !== 1'b0 ||
                byte_idx !== 2'((cyc - 1) / (FRAME * CPB)))
               flag_err++;
         end else if (cyc == WORD_CYC + 1) begin
            gap[0] = tx_serial;
            if (tx_busy !== 1'b0 || word_ready !== 1'b0 || byte_idx !== 2'd3) flag_err++;
         end else begin
            gap[1] = tx_serial;
            if (tx_busy !== 1'b0 || word_ready !== 1'b1 || byte_idx !== 2'd0) flag_err++;
         end
         if (tx_done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
         end
         if (cyc == 1) begin
            if (v.mode == 1) begin
               word_valid = 1'b1;
               word_data  = v.next;
            end else begin
               word_valid = 1'b0;
               word_data  = ~v.word;
            end
         end
         if (v.mode == 2 && cyc == 20) begin
            word_valid = 1'b1;
            word_data  = 32'hFFFF_FFFF;
         end
         if (v.mode == 2 && cyc == 21) begin
            word_valid = 1'b0;
            word_data  = ~v.word;
         end
      end
      for (int f = 0; f < 4; f++) begin
         byt = eb_all[8*f +: 8];
`ifdef UART_TX_PARITY_EN
         exp_f = {1'b1, v.par[f], byt, 1'b0};
`else
         exp_f = {1'b0, 1'b1, byt, 1'b0};
`endif
         cap_f  = '0;
         stable = 1'b1;
         for (int k = 0; k < FRAME; k++) begin
            base = f * FRAME * CPB + k * CPB;
            cap_f[k] = line_tr[base + CPB/2];
            for (int s = 0; s < CPB; s++)
               if (line_tr[base + s] !== line_tr[base + CPB/2]) stable = 1'b0;
         end
         chk($sformatf("w%0d_frame%0d", idx, f), {stable, cap_f}, {1'b1, exp_f});
      end
      chk($sformatf("w%0d_done_count", idx), done_cnt, 1);
      chk($sformatf("w%0d_done_latency", idx), done_cyc, LAT);
      chk($sformatf("w%0d_flags", idx), flag_err, 0);
      chk($sformatf("w%0d_gap_high", idx), gap, 2'b11);
   endtask

   initial begin
      #200us;
      $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
      $fatal(1);
   end

   initial begin
      int bad;
      int n;
      // word, bytes 0..3 on the line, even-parity bits per byte, mode, next word
      tbl[0] = '{32'h1234_5678, 8'h78, 8'h56, 8'h34, 8'h12, 4'b0100, 0, 32'h0};
      tbl[1] = '{32'hA5A5_A5A5, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 4'b0000, 1, 32'h0000_FFFF};
      tbl[2] = '{32'h0000_FFFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 4'b0000, 0, 32'h0};
      tbl[3] = '{32'h0000_0103, 8'h03, 8'h01, 8'h00, 8'h00, 4'b0010, 2, 32'h0};

      reset      = 1'b1;
      word_valid = 1'b0;
      word_data  = 32'h0;
      repeat (3) @(negedge clk);
      chk("rst_tx_serial",  tx_serial,  1'b1);
      chk("rst_word_ready", word_ready, 1'b1);
      chk("rst_tx_busy",    tx_busy,    1'b0);
      chk("rst_tx_done",    tx_done,    1'b0);
      chk("rst_byte_idx",   byte_idx,   2'd0);
      reset = 1'b0;
      @(negedge clk);
      chk("idle_after_rst_ready", word_ready, 1'b1);

      for (int i = 0; i < 4; i++) begin
         run_word(tbl[i], i);
         if (tbl[i].mode == 2) begin
            bad = 0;
            for (int c = 0; c < 40; c++) begin
               @(negedge clk);
               if (tx_serial !== 1'b1 || word_ready !== 1'b1 || tx_done !== 1'b0) bad++;
            end
            chk($sformatf("w%0d_no_extra_word", i), bad, 0);
         end
      end

      // Reset in the middle of byte 2 of DEADBEEF.
      @(negedge clk);
      word_valid = 1'b1;
      word_data  = 32'hDEAD_BEEF;
      n = 0;
      while (!word_ready && n < 500) begin
         @(negedge clk);
         n++;
      end
      chk("rstmid_accept_ready", word_ready, 1'b1);
      for (int c = 1; c <= 90; c++) begin
         @(negedge clk);
         if (c == 1) begin
            word_valid = 1'b0;
            word_data  = 32'h0;
         end
      end
      chk("rstmid_byte_idx_before", byte_idx, 2'd2);
      chk("rstmid_busy_before", tx_busy, 1'b1);
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk("rstmid_tx_serial", tx_serial, 1'b1);
      chk("rstmid_byte_idx",  byte_idx,  2'd0);
      chk("rstmid_tx_busy",   tx_busy,   1'b0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      bad = 0;
      for (int c = 0; c < 200; c++) begin
         @(negedge clk);
         if (tx_done !== 1'b0 || tx_serial !== 1'b1) bad++;
      end
      chk("rstmid_abandoned", bad, 0);
      chk("rstmid_ready_after", word_ready, 1'b1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
